stage_if_buffered: RTL and testbench

- Parametrised successor to the single-cycle fetch stage.
- Decouples PC generation from decode using a request/response instruction-memory port, up to MAX_OUTSTANDING in-flight fetches, and a FETCH_DEPTH-entry instruction queue of {pc, inst} pairs.
- Sits between the instruction memory and decode, with a valid/ready handshake toward decode.
- A redirect (jump/branch) flushes the queue and discards stale in-flight responses.

---
 rtl/stage_if_buffered_pkg.sv | 10 +
 rtl/stage_if_buffered_inst_queue.sv | 53 +++++
 rtl/stage_if_buffered.sv | 98 +++++++++
 tb/tb_stage_if_buffered.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_buffered_pkg.sv
// Constants shared by the buffered fetch stage: codebase widths, the NOP
// used as the idle instruction, and the byte size of one instruction.
package stage_if_buffered_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int WORD_WIDTH     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int INST_BYTES     = 4;

endpackage

// File: rtl/stage_if_buffered_inst_queue.sv
// Synchronous FIFO of {pc, inst} pairs between instruction memory and decode.
// A flush empties the queue and takes priority over a same-cycle push.
module inst_queue
  import stage_if_buffered_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stage_if_buffered.sv
// Buffered fetch stage: issues PC requests to instruction memory under a credit
// limit, queues responses for decode and drops stale responses after a redirect.
module stage_if_buffered
  import stage_if_buffered_pkg::*;
#(
  parameter int ADDR_WIDTH      = stage_if_buffered_pkg::MEM_ADDR_WIDTH,
  parameter int WORD_WIDTH      = stage_if_buffered_pkg::WORD_WIDTH,
  parameter int FETCH_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_tgt,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [WORD_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [WORD_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W   = $clog2(FETCH_DEPTH + 1);
  localparam int ENTRY_W = ADDR_WIDTH + WORD_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      discard;
  logic [CNT_W-1:0]      occupancy;
  logic [ENTRY_W-1:0]    head_entry;
  logic [31:0]           credits_used;
  logic                  q_empty;
  logic                  q_full;
  logic                  accept;
  logic                  resp_keep;
  logic                  pop;

  assign target_pc    = redirect_tgt & ~ADDR_WIDTH'(3);
  assign credits_used = 32'(outstanding) + 32'(occupancy);

  // Every in-flight request already owns a queue slot, so responses never stall.
  assign imem_req_valid = !redirect_en && !q_full
                          && (credits_used < 32'(FETCH_DEPTH))
                          && (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (discard == '0) && !redirect_en;

  assign inst_valid = !q_empty;
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? head_entry[WORD_WIDTH-1:0] : WORD_WIDTH'(NOP_INST);
  assign inst_pc    = inst_valid ? head_entry[ENTRY_W-1:WORD_WIDTH] : '0;

  inst_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FETCH_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (resp_keep),
    .push_data ({resp_pc, imem_resp_data}),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (q_empty),
    .full      (q_full),
    .count     (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_en) begin
      // Whatever is still in flight after this edge belongs to the old path.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= outstanding - OUT_W'(imem_resp_valid);
      discard     <= outstanding - OUT_W'(imem_resp_valid);
    end else begin
      if (accept)    fetch_pc <= fetch_pc + PC_STEP;
      if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding + OUT_W'(accept) - OUT_W'(imem_resp_valid);
      if (imem_resp_valid && (discard != '0)) discard <= discard - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_stage_if_buffered.sv
// Directed bench for stage_if_buffered with an in-order, fixed-latency
// instruction memory model driven from the stimulus sequence.
module tb_stage_if_buffered;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_tgt;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   lat          = 1;
  int   acc_count    = 0;
  req_t pend[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  stage_if_buffered dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_en     (redirect_en),
    .redirect_tgt    (redirect_tgt),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr ^ 32'h1357_2468;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs; the memory answers its oldest request once due.
  task automatic applyStimulus(input logic rd, input logic [31:0] tgt,
                               input logic rq_ready, input logic in_ready);
    redirect_en    = rd;
    redirect_tgt   = tgt;
    imem_req_ready = rq_ready;
    inst_ready     = in_ready;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memData(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic stepClock();
    req_t r;
    if (imem_resp_valid) void'(pend.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
      acc_count++;
    end
    if (rst) pend.delete();
    if (!rst) begin
      checkOutput("outstanding_bound", 64'(dut.outstanding <= 2), 64'd1);
      checkOutput("discard_bound", 64'(dut.discard <= 2), 64'd1);
      checkOutput("occupancy_bound", 64'(dut.occupancy <= 4), 64'd1);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic doReset(input int latency);
    lat = latency;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    rst = 1'b0;
    acc_count = 0;
  endtask

  initial begin
    rst             = 1'b1;
    redirect_en     = 1'b0;
    redirect_tgt    = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    @(negedge clk);

    // Sequential fetch after reset, 1-cycle memory, decode always ready
    doReset(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("rst_req_addr", 64'(imem_req_addr), 64'h0);
    checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_inst_nop", 64'(inst), 64'(NOP));
    checkOutput("rst_inst_pc", 64'(inst_pc), 64'h0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("seq_c1_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("seq_c1_req_addr", 64'(imem_req_addr), 64'h4);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("seq_c2_inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("seq_c2_inst_pc", 64'(inst_pc), 64'h0);
    checkOutput("seq_c2_inst", 64'(inst), 64'(memData(32'h0)));
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("seq_c3_inst_pc", 64'(inst_pc), 64'h4);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("seq_c4_inst_pc", 64'(inst_pc), 64'h8);
    stepClock();

    // Decode stalled: queue fills to 4 and requests stop
    doReset(1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      stepClock();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("full_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("full_accept_count", 64'(acc_count), 64'd4);
    checkOutput("full_inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("full_inst_pc", 64'(inst_pc), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("drain_r0_inst_pc", 64'(inst_pc), 64'h0);
    checkOutput("drain_r0_req_valid", 64'(imem_req_valid), 64'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("drain_r1_inst_pc", 64'(inst_pc), 64'h4);
    checkOutput("drain_r1_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("drain_r1_req_addr", 64'(imem_req_addr), 64'h10);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("drain_r2_inst_pc", 64'(inst_pc), 64'h8);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("drain_r3_inst_pc", 64'(inst_pc), 64'hC);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("drain_r4_inst_pc", 64'(inst_pc), 64'h10);
    stepClock();

    // Redirect with two requests in flight, 3-cycle memory
    doReset(3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b1, 32'h103, 1'b1, 1'b1);
    checkOutput("rd3_req_valid", 64'(imem_req_valid), 64'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rd3_a3_req_addr", 64'(imem_req_addr), 64'h100);
    checkOutput("rd3_a3_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rd3_a3_inst_valid", 64'(inst_valid), 64'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rd3_a4_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("rd3_a4_inst_valid", 64'(inst_valid), 64'd0);
    stepClock();
    for (int i = 5; i <= 7; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("rd3_stale_inst_valid", 64'(inst_valid), 64'd0);
      stepClock();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rd3_a8_inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("rd3_a8_inst_pc", 64'(inst_pc), 64'h100);
    checkOutput("rd3_a8_inst", 64'(inst), 64'(memData(32'h100)));
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rd3_a9_inst_pc", 64'(inst_pc), 64'h104);
    stepClock();

    // Redirect coinciding with a valid response and a decode pop
    doReset(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    checkOutput("rdp_pop_inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("rdp_req_valid", 64'(imem_req_valid), 64'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rdp_a3_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rdp_a3_inst_nop", 64'(inst), 64'(NOP));
    checkOutput("rdp_a3_inst_pc", 64'(inst_pc), 64'h0);
    checkOutput("rdp_a3_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("rdp_a3_req_addr", 64'(imem_req_addr), 64'h200);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rdp_a4_inst_valid", 64'(inst_valid), 64'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rdp_a5_inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("rdp_a5_inst_pc", 64'(inst_pc), 64'h200);
    stepClock();

    // Memory not ready for 5 cycles: request held stable
    doReset(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    stepClock();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("stall_req_valid", 64'(imem_req_valid), 64'd1);
      checkOutput("stall_req_addr", 64'(imem_req_addr), 64'h4);
      stepClock();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("stall_a6_req_addr", 64'(imem_req_addr), 64'h4);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("stall_a7_req_addr", 64'(imem_req_addr), 64'h8);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("stall_a8_inst_pc", 64'(inst_pc), 64'h4);
    stepClock();

    // PC wrap-around at the top of the address space
    doReset(1);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap_a1_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("wrap_a1_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap_a2_req_addr", 64'(imem_req_addr), 64'h0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap_a3_inst_pc", 64'(inst_pc), 64'hFFFF_FFFC);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap_a4_inst_pc", 64'(inst_pc), 64'h0);
    checkOutput("wrap_a4_inst", 64'(inst), 64'(memData(32'h0)));
    stepClock();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
